// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: assigns note events to a bank of envelope voices,
// preferring free voices, then releasing voices, and finally stealing the oldest gated voice.
module voice_alloc #(
   parameter int NVOICE     = 4,
   parameter int NBIT_NOTE  = 7,
   parameter int RETRIG_CYC = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ev_valid,
   output logic                          ev_ready,
   input  logic                          ev_on,
   input  logic [NBIT_NOTE-1:0]          ev_note,
   input  logic [NVOICE-1:0]             voice_active,
   output logic [NVOICE-1:0]             gate,
   output logic [NVOICE*NBIT_NOTE-1:0]   voice_note,
   output logic                          alloc_valid,
   output logic [$clog2(NVOICE)-1:0]     alloc_idx,
   output logic                          steal
);

   localparam int IW = $clog2(NVOICE);
   localparam int CW = $clog2(RETRIG_CYC + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DECIDE = 2'd1;
   localparam logic [1:0] ST_RETRIG = 2'd2;
   localparam logic [1:0] ST_GRANT  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic                 on_q, on_d;
   logic [NBIT_NOTE-1:0] note_q, note_d;
   logic [IW-1:0]        tgt_q, tgt_d;
   logic                 steal_pend_q, steal_pend_d;
   logic [NVOICE-1:0]    off_mask_q, off_mask_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [NVOICE-1:0]    gate_q, gate_d;
   logic [NBIT_NOTE-1:0] vnote_q [NVOICE];
   logic [NBIT_NOTE-1:0] vnote_d [NVOICE];
   logic [IW-1:0]        rank_q [NVOICE];
   logic [IW-1:0]        rank_d [NVOICE];
   logic                 alloc_valid_q, alloc_valid_d;
   logic [IW-1:0]        alloc_idx_q, alloc_idx_d;
   logic                 steal_q, steal_d;

   logic                 hold_hit, free_hit, rel_hit;
   logic [IW-1:0]        hold_idx, free_idx, rel_idx, old_idx;
   logic [NVOICE-1:0]    off_match;

   // Voice classification and lowest-index candidate search, used only in DECIDE.
   always_comb begin
      hold_hit  = 1'b0;
      free_hit  = 1'b0;
      rel_hit   = 1'b0;
      hold_idx  = '0;
      free_idx  = '0;
      rel_idx   = '0;
      old_idx   = '0;
      off_match = '0;
      for (int unsigned v = 0; v < NVOICE; v++) begin
         if (gate_q[v] && (vnote_q[v] == note_q)) begin
            off_match[v] = 1'b1;
            if (!hold_hit) begin
               hold_hit = 1'b1;
               hold_idx = IW'(v);
            end
         end
         if (!gate_q[v] && !voice_active[v] && !free_hit) begin
            free_hit = 1'b1;
            free_idx = IW'(v);
         end
         if (!gate_q[v] && voice_active[v] && !rel_hit) begin
            rel_hit = 1'b1;
            rel_idx = IW'(v);
         end
         if (rank_q[v] == '0) begin
            old_idx = IW'(v);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      on_d          = on_q;
      note_d        = note_q;
      tgt_d         = tgt_q;
      steal_pend_d  = steal_pend_q;
      off_mask_d    = '0;
      cnt_d         = cnt_q;
      // A note-off decided last cycle lands here, one cycle after DECIDE.
      gate_d        = gate_q & ~off_mask_q;
      vnote_d       = vnote_q;
      rank_d        = rank_q;
      alloc_valid_d = 1'b0;
      alloc_idx_d   = alloc_idx_q;
      steal_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ev_valid) begin
               on_d    = ev_on;
               note_d  = ev_note;
               state_d = ST_DECIDE;
            end
         end
         ST_DECIDE: begin
            if (!on_q) begin
               off_mask_d = off_match;
               state_d    = ST_IDLE;
            end else if (hold_hit) begin
               tgt_d        = hold_idx;
               steal_pend_d = 1'b0;
               cnt_d        = CW'(RETRIG_CYC - 1);
               state_d      = ST_RETRIG;
            end else if (free_hit) begin
               tgt_d        = free_idx;
               steal_pend_d = 1'b0;
               state_d      = ST_GRANT;
            end else if (rel_hit) begin
               tgt_d        = rel_idx;
               steal_pend_d = 1'b0;
               state_d      = ST_GRANT;
            end else begin
               tgt_d        = old_idx;
               steal_pend_d = 1'b1;
               cnt_d        = CW'(RETRIG_CYC - 1);
               state_d      = ST_RETRIG;
            end
         end
         ST_RETRIG: begin
            gate_d[tgt_q] = 1'b0;
            if (cnt_q == '0) begin
               state_d = ST_GRANT;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_GRANT: begin
            gate_d[tgt_q]  = 1'b1;
            vnote_d[tgt_q] = note_q;
            alloc_valid_d  = 1'b1;
            alloc_idx_d    = tgt_q;
            steal_d        = steal_pend_q;
            for (int unsigned v = 0; v < NVOICE; v++) begin
               if (IW'(v) == tgt_q) begin
                  rank_d[v] = IW'(NVOICE - 1);
               end else if (rank_q[v] > rank_q[tgt_q]) begin
                  rank_d[v] = rank_q[v] - IW'(1);
               end
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         on_q          <= 1'b0;
         note_q        <= '0;
         tgt_q         <= '0;
         steal_pend_q  <= 1'b0;
         off_mask_q    <= '0;
         cnt_q         <= '0;
         gate_q        <= '0;
         alloc_valid_q <= 1'b0;
         alloc_idx_q   <= '0;
         steal_q       <= 1'b0;
         for (int unsigned v = 0; v < NVOICE; v++) begin
            vnote_q[v] <= '0;
            rank_q[v]  <= IW'(v);
         end
      end else begin
         state_q       <= state_d;
         on_q          <= on_d;
         note_q        <= note_d;
         tgt_q         <= tgt_d;
         steal_pend_q  <= steal_pend_d;
         off_mask_q    <= off_mask_d;
         cnt_q         <= cnt_d;
         gate_q        <= gate_d;
         alloc_valid_q <= alloc_valid_d;
         alloc_idx_q   <= alloc_idx_d;
         steal_q       <= steal_d;
         vnote_q       <= vnote_d;
         rank_q        <= rank_d;
      end
   end

   always_comb begin
      voice_note = '0;
      for (int unsigned v = 0; v < NVOICE; v++) begin
         voice_note[v*NBIT_NOTE +: NBIT_NOTE] = vnote_q[v];
      end
   end

   assign ev_ready    = (state_q == ST_IDLE);
   assign gate        = gate_q;
   assign alloc_valid = alloc_valid_q;
   assign alloc_idx   = alloc_idx_q;
   assign steal       = steal_q;

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc (NVOICE=4, NBIT_NOTE=7, RETRIG_CYC=2) with hand-computed expectations.
module tb_voice_alloc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ev_valid = 1'b0;
   logic        ev_ready;
   logic        ev_on = 1'b0;
   logic [6:0]  ev_note = '0;
   logic [3:0]  voice_active = '0;
   logic [3:0]  gate;
   logic [27:0] voice_note;
   logic        alloc_valid;
   logic [1:0]  alloc_idx;
   logic        steal;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [3:0]  exp_gate = '0;

   voice_alloc #(.NVOICE(4), .NBIT_NOTE(7), .RETRIG_CYC(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .ev_valid     (ev_valid),
      .ev_ready     (ev_ready),
      .ev_on        (ev_on),
      .ev_note      (ev_note),
      .voice_active (voice_active),
      .gate         (gate),
      .voice_note   (voice_note),
      .alloc_valid  (alloc_valid),
      .alloc_idx    (alloc_idx),
      .steal        (steal)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] vn(input int i);
      return voice_note[i*7 +: 7];
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      ev_valid = 1'b0;
      voice_active = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_gate = '0;
   endtask

   task automatic send(input logic on, input logic [6:0] nt);
      int w = 0;
      @(negedge clk);
      while (!ev_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!ev_ready) check_val("ready_timeout", ev_ready, 1);
      ev_valid = 1'b1;
      ev_on    = on;
      ev_note  = nt;
      @(posedge clk);
      #1 ev_valid = 1'b0;
   endtask

   task automatic on_ev(input logic [6:0] nt, input int idx, input logic stl, input int lat);
      logic [3:0] g0;
      logic [3:0] gk;
      g0 = exp_gate;
      send(1'b1, nt);
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k < lat) begin
            gk = g0;
            if (k >= 2) gk[idx] = 1'b0;
            check_val("gate_wait", gate, gk);
            check_val("ready_busy", ev_ready, 0);
            check_val("av_wait", alloc_valid, 0);
         end
      end
      exp_gate = g0;
      exp_gate[idx] = 1'b1;
      check_val("gate_grant", gate, exp_gate);
      check_val("alloc_valid", alloc_valid, 1);
      check_val("alloc_idx", alloc_idx, idx);
      check_val("steal", steal, stl);
      check_val("voice_note", vn(idx), nt);
   endtask

   task automatic off_ev(input logic [6:0] nt, input logic [3:0] mask);
      send(1'b0, nt);
      @(posedge clk);
      @(negedge clk);
      check_val("off_hold", gate, exp_gate);
      check_val("off_ready", ev_ready, 1);
      @(posedge clk);
      @(negedge clk);
      exp_gate = exp_gate & ~mask;
      check_val("off_gate", gate, exp_gate);
      check_val("off_av", alloc_valid, 0);
   endtask

   initial begin
      // 1) reset state and first allocation
      do_reset();
      check_val("rst_gate", gate, 0);
      check_val("rst_ready", ev_ready, 1);
      check_val("rst_av", alloc_valid, 0);
      check_val("rst_idx", alloc_idx, 0);
      check_val("rst_steal", steal, 0);
      check_val("rst_notes", voice_note, 0);
      on_ev(7'd60, 0, 1'b0, 2);
      @(posedge clk);
      @(negedge clk);
      check_val("av_pulse", alloc_valid, 0);
      check_val("idx_hold", alloc_idx, 0);

      // 2) steal the oldest gated voice
      do_reset();
      on_ev(7'd60, 0, 1'b0, 2);
      voice_active = 4'b0001;
      on_ev(7'd62, 1, 1'b0, 2);
      voice_active = 4'b0011;
      on_ev(7'd64, 2, 1'b0, 2);
      voice_active = 4'b0111;
      on_ev(7'd65, 3, 1'b0, 2);
      voice_active = 4'b1111;
      on_ev(7'd67, 0, 1'b1, 4);
      @(posedge clk);
      @(negedge clk);
      check_val("steal_pulse", steal, 0);
      check_val("keep_v1", vn(1), 62);

      // 3) free voice preferred over releasing voice
      do_reset();
      on_ev(7'd60, 0, 1'b0, 2);
      voice_active = 4'b0001;
      off_ev(7'd60, 4'b0001);
      on_ev(7'd62, 1, 1'b0, 2);
      check_val("t3_gate", gate, 4'b0010);
      check_val("t3_relnote", vn(0), 60);

      // 4) releasing voice reused, then rank order observed through successive steals
      do_reset();
      on_ev(7'd60, 0, 1'b0, 2);
      on_ev(7'd62, 1, 1'b0, 2);
      on_ev(7'd64, 2, 1'b0, 2);
      on_ev(7'd65, 3, 1'b0, 2);
      voice_active = 4'b1111;
      off_ev(7'd62, 4'b0010);
      on_ev(7'd70, 1, 1'b0, 2);
      on_ev(7'd72, 0, 1'b1, 4);
      on_ev(7'd74, 2, 1'b1, 4);
      on_ev(7'd76, 3, 1'b1, 4);

      // 5) retrigger of a held note reuses the same voice
      do_reset();
      on_ev(7'd60, 0, 1'b0, 2);
      voice_active = 4'b0001;
      on_ev(7'd60, 0, 1'b0, 4);
      check_val("t5_gate", gate, 4'b0001);

      // 6) async reset in the middle of a retrigger, then no-op note-offs
      do_reset();
      on_ev(7'd60, 0, 1'b0, 2);
      on_ev(7'd62, 1, 1'b0, 2);
      voice_active = 4'b0011;
      send(1'b1, 7'd60);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_val("t6_retrig_low", gate, 4'b0010);
      #2 rst = 1'b1;
      #1;
      check_val("t6_rst_gate", gate, 0);
      check_val("t6_rst_ready", ev_ready, 1);
      check_val("t6_rst_idx", alloc_idx, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_gate = '0;
      voice_active = '0;
      on_ev(7'd48, 0, 1'b0, 2);
      voice_active = 4'b0001;
      off_ev(7'd99, 4'b0000);
      off_ev(7'd48, 4'b0001);
      off_ev(7'd48, 4'b0000);
      check_val("t6_keep_note", vn(0), 48);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
